// File: rtl/uart_rx_fsm_pkg.sv
// rtl/uart_rx_fsm_pkg.sv - shared UART receiver definitions: states, frame size, check point
package uart_rx_fsm_pkg;

    localparam int UART_DATA_BITS = 8;
    localparam int CHECK_OFFSET   = 2;

    typedef enum logic [4:0] {
        IDLE   = 5'b00001,
        START  = 5'b00010,
        DATA   = 5'b00100,
        PARITY = 5'b01000,
        STOP   = 5'b10000
    } state_t;

    // Oversample edge at which the sampled bit is settled (Prescale/2+2).
    function automatic logic [5:0] check_point(input logic [5:0] prescale);
        return (prescale >> 1) + 6'(CHECK_OFFSET);
    endfunction

endpackage

// File: rtl/uart_rx_fsm_edge_bit_counter.sv
// rtl/uart_rx_fsm_edge_bit_counter.sv - oversample edge counter and frame bit counter
module edge_bit_counter #(
    parameter int EDGE_W = 5,
    parameter int BIT_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              clear,
    input  logic [5:0]        Prescale,
    output logic [EDGE_W-1:0] edge_count,
    output logic [BIT_W-1:0]  bit_count,
    output logic              bit_end
);

    localparam int CW = (EDGE_W > 6) ? EDGE_W : 6;

    logic [CW-1:0] edge_ext;
    logic [CW-1:0] edge_last;

    assign edge_ext  = CW'(edge_count);
    assign edge_last = CW'(Prescale) - CW'(1);
    assign bit_end   = enable && (edge_ext == edge_last);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            edge_count <= '0;
            bit_count  <= '0;
        end else if (!enable || clear) begin
            edge_count <= '0;
            bit_count  <= '0;
        end else if (bit_end) begin
            edge_count <= '0;
            bit_count  <= bit_count + BIT_W'(1);
        end else begin
            edge_count <= edge_count + EDGE_W'(1);
        end
    end

endmodule

// File: rtl/uart_rx_fsm.sv
// rtl/uart_rx_fsm.sv - UART receive frame controller: sequences start/data/parity/stop bits
module uart_rx_fsm
    import uart_rx_fsm_pkg::*;
#(
    parameter int DATA_BITS = UART_DATA_BITS,
    parameter int EDGE_W    = 5,
    parameter int BIT_W     = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              RX_IN,
    input  logic              PAR_EN,
    input  logic [5:0]        Prescale,
    input  logic              par_err,
    input  logic              strt_glitch,
    input  logic              stp_err,
    output logic [EDGE_W-1:0] edge_count,
    output logic [BIT_W-1:0]  bit_count,
    output logic              dat_samp_en,
    output logic              deser_en,
    output logic              strt_chk_en,
    output logic              par_chk_en,
    output logic              stp_chk_en,
    output logic              data_valid,
    output logic              frame_err
);

    state_t state;
    state_t next_state;
    logic   par_en_q;
    logic   data_valid_q;
    logic   frame_err_q;
    logic   bit_end;
    logic   cnt_enable;
    logic   cnt_clear;
    logic   frame_end;
    logic   err;
    logic   frame_start;

    assign cnt_enable  = (state != IDLE);
    // Counters restart on any return to IDLE and on a back-to-back STOP->START.
    assign cnt_clear   = (next_state == IDLE) || ((state == STOP) && bit_end);
    assign frame_end   = (state == STOP) && bit_end;
    assign err         = stp_err | (par_en_q & par_err);
    assign frame_start = (next_state == START) && (state != START);

    edge_bit_counter #(
        .EDGE_W (EDGE_W),
        .BIT_W  (BIT_W)
    ) u_counter (
        .clk        (clk),
        .rst        (rst),
        .enable     (cnt_enable),
        .clear      (cnt_clear),
        .Prescale   (Prescale),
        .edge_count (edge_count),
        .bit_count  (bit_count),
        .bit_end    (bit_end)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            par_en_q     <= 1'b0;
            data_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state        <= next_state;
            data_valid_q <= frame_end & ~err;
            frame_err_q  <= frame_end & err;
            if (frame_start) begin
                par_en_q <= PAR_EN;
            end
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (!RX_IN) next_state = START;
            end
            START: begin
                if (bit_end) next_state = strt_glitch ? IDLE : DATA;
            end
            DATA: begin
                if (bit_end && (bit_count == BIT_W'(DATA_BITS)))
                    next_state = par_en_q ? PARITY : STOP;
            end
            PARITY: begin
                if (bit_end) next_state = STOP;
            end
            STOP: begin
                if (bit_end) next_state = RX_IN ? IDLE : START;
            end
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        dat_samp_en = (state != IDLE);
        strt_chk_en = (state == START);
        par_chk_en  = (state == PARITY);
        stp_chk_en  = (state == STOP);
        deser_en    = (state == DATA) && (6'(edge_count) == check_point(Prescale));
        data_valid  = data_valid_q;
        frame_err   = frame_err_q;
    end

endmodule

// File: tb/tb_uart_rx_fsm.sv
// tb/tb_uart_rx_fsm.sv - scoreboard bench for uart_rx_fsm
module tb_uart_rx_fsm;

    localparam int EDGE_W = 5;
    localparam int BIT_W  = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              RX_IN = 1'b1;
    logic              PAR_EN = 1'b0;
    logic [5:0]        Prescale = 6'd8;
    logic              par_err = 1'b0;
    logic              strt_glitch = 1'b0;
    logic              stp_err = 1'b0;
    logic [EDGE_W-1:0] edge_count;
    logic [BIT_W-1:0]  bit_count;
    logic              dat_samp_en;
    logic              deser_en;
    logic              strt_chk_en;
    logic              par_chk_en;
    logic              stp_chk_en;
    logic              data_valid;
    logic              frame_err;

    uart_rx_fsm #(
        .DATA_BITS (8),
        .EDGE_W    (EDGE_W),
        .BIT_W     (BIT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .RX_IN       (RX_IN),
        .PAR_EN      (PAR_EN),
        .Prescale    (Prescale),
        .par_err     (par_err),
        .strt_glitch (strt_glitch),
        .stp_err     (stp_err),
        .edge_count  (edge_count),
        .bit_count   (bit_count),
        .dat_samp_en (dat_samp_en),
        .deser_en    (deser_en),
        .strt_chk_en (strt_chk_en),
        .par_chk_en  (par_chk_en),
        .stp_chk_en  (stp_chk_en),
        .data_valid  (data_valid),
        .frame_err   (frame_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int at;
        bit err;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   total = 0;
    int   bad = 0;
    int   ps = 8;
    int   deser_cnt = 0;
    bit   par_seen = 1'b0;
    int   last_pulse = 0;
    int   prev_pulse = 0;

    task automatic chk_val(input string tag, input longint got, input longint exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (deser_en) deser_cnt++;
        if (par_chk_en) par_seen = 1'b1;
        if (data_valid || frame_err) begin
            chk_val("pulse_excl", data_valid & frame_err, 0);
            if (sb.size() == 0) begin
                chk_val("pulse_unexpected", cyc, -1);
            end else begin
                mon_e = sb.pop_front();
                chk_val("pulse_cycle", cyc, mon_e.at);
                chk_val("pulse_kind", frame_err, mon_e.err);
            end
            prev_pulse = last_pulse;
            last_pulse = cyc;
        end
    end

    task automatic set_ps(input int p);
        ps = p;
        Prescale = 6'(p);
    endtask

    task automatic idle(input int n);
        RX_IN = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Called 1 time unit after a posedge; returns aligned the same way at the stop-end cycle.
    task automatic send_frame(input logic [7:0] d, input logic pe, input logic pe_err, input logic se_err);
        int          nb;
        logic [10:0] bits;
        exp_t        e;
        nb = pe ? 11 : 10;
        bits = '1;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[i+1] = d[i];
        if (pe) bits[9] = ^d;
        PAR_EN    = pe;
        par_err   = pe_err;
        stp_err   = se_err;
        deser_cnt = 0;
        par_seen  = 1'b0;
        e.at  = cyc + 1 + nb * ps;
        e.err = se_err | (pe & pe_err);
        sb.push_back(e);
        for (int b = 0; b < nb; b++) begin
            RX_IN = bits[b];
            @(posedge clk);
            #1;
            chk_val("bit_idx", bit_count, b);
            chk_val("edge_first", edge_count, 0);
            if (b == 0) begin
                chk_val("strt_chk_en", strt_chk_en, 1);
                PAR_EN = ~pe;
            end
            if (pe && b == nb - 2) chk_val("par_chk_en", par_chk_en, 1);
            if (b == nb - 1) chk_val("stp_chk_en", stp_chk_en, 1);
            repeat (ps - 1) @(posedge clk);
            #1;
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk_val({tag, "_edge"}, edge_count, 0);
        chk_val({tag, "_bit"}, bit_count, 0);
        chk_val({tag, "_outs"}, {dat_samp_en, deser_en, strt_chk_en, par_chk_en,
                                 stp_chk_en, data_valid, frame_err}, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog cyc=%0d exp=finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_val("idle_hold", dat_samp_en, 0);

        set_ps(8);
        send_frame(8'hA5, 1'b1, 1'b0, 1'b0);
        chk_val("t1_deser", deser_cnt, 8);
        idle(10);
        chk_val("t1_sb", sb.size(), 0);

        set_ps(16);
        send_frame(8'h3C, 1'b0, 1'b1, 1'b0);
        chk_val("t2_deser", deser_cnt, 8);
        chk_val("t2_par_seen", par_seen, 0);
        idle(10);
        par_err = 1'b0;

        set_ps(8);
        deser_cnt   = 0;
        strt_glitch = 1'b1;
        RX_IN       = 1'b0;
        repeat (ps) @(posedge clk);
        #1;
        chk_val("t3_end_edge", edge_count, 7);
        chk_val("t3_in_start", strt_chk_en, 1);
        RX_IN = 1'b1;
        @(posedge clk);
        #1;
        chk_all_zero("t3_idle");
        strt_glitch = 1'b0;
        idle(20);
        chk_val("t3_deser", deser_cnt, 0);
        chk_val("t3_still_idle", dat_samp_en, 0);

        set_ps(32);
        send_frame(8'h5A, 1'b1, 1'b1, 1'b0);
        idle(5);
        send_frame(8'hFF, 1'b0, 1'b1, 1'b1);
        idle(5);
        par_err = 1'b0;
        stp_err = 1'b0;

        set_ps(8);
        send_frame(8'h12, 1'b1, 1'b0, 1'b0);
        send_frame(8'h34, 1'b1, 1'b0, 1'b0);
        idle(5);
        chk_val("t5_gap", last_pulse - prev_pulse, 88);

        set_ps(8);
        PAR_EN = 1'b0;
        RX_IN  = 1'b0;
        repeat (36) @(posedge clk);
        #3;
        chk_val("t6_pre_edge", edge_count, 3);
        chk_val("t6_pre_bit", bit_count, 4);
        rst = 1'b0;
        #1;
        chk_all_zero("t6_rst");
        RX_IN = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk_all_zero("t6_after");

        chk_val("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_rx_fsm.md
Name: uart_rx_fsm

Overview:
- Frame-level controller for the UART receiver. Tracks start, data, parity and stop bits and owns the oversampling edge/bit counters.
- Drives the enables for the sampler, deserializer, start/parity/stop checkers, and consumes their error flags.
- Issues the final data_valid or frame_err pulse per frame.
- Sits between the synchronized RX line and the per-bit check stages. Its edge_count output is the one the parity checker compares against Prescale/2+2.

Parameters:
- DATA_BITS, 8, data bits per frame, LSB first.
- EDGE_W, 5, edge counter width; must hold Prescale-1.
- BIT_W, 4, bit counter width; must hold DATA_BITS+2.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-low reset.
- RX_IN  input  1  serial line, already synchronized upstream; idle high.
- PAR_EN  input  1  frame carries a parity bit; latched at frame start.
- Prescale  input  6  oversampling ratio; legal values 8, 16, 32; must be stable during a frame.
- par_err  input  1  parity checker result; sticky, registered.
- strt_glitch  input  1  start checker result; high = false start.
- stp_err  input  1  stop checker result.
- edge_count  output  EDGE_W  oversample edge index within the current bit, 0..Prescale-1.
- bit_count  output  BIT_W  bit index within the frame: 0 = start, 1..8 = data, 9 = parity or stop, 10 = stop.
- dat_samp_en  output  1  sampler enable.
- deser_en  output  1  deserializer shift strobe.
- strt_chk_en  output  1  start checker enable.
- par_chk_en  output  1  parity checker enable.
- stp_chk_en  output  1  stop checker enable.
- data_valid  output  1  one-cycle pulse: frame good, P_data valid.
- frame_err  output  1  one-cycle pulse: frame ended with parity or stop error.

Behaviour:
- Reset (rst low, asynchronous): state returns to IDLE immediately, even mid-frame. edge_count=0, bit_count=0, all outputs 0, latched PAR_EN=0.
- States: IDLE, START, DATA, PARITY, STOP. Encoding is one-hot.
- Bit end is the cycle where edge_count==Prescale-1.
- Check point is the cycle where edge_count==Prescale/2+2, when the sampled bit is valid.
- Counters:
  - In IDLE, both counters are held at 0.
  - In any other state, edge_count increments every clk and wraps to 0 at bit end.
  - bit_count increments at each bit end.
  - Leaving any state back to IDLE clears both counters.
- IDLE: RX_IN==0 -> START. The first START cycle has edge_count=0. Latch PAR_EN on this edge.
- START: at bit end, strt_glitch=1 -> IDLE with no pulse; otherwise -> DATA.
- DATA: at the bit end where bit_count==DATA_BITS -> PARITY if latched PAR_EN=1, otherwise STOP.
- PARITY: at bit end -> STOP.
- STOP: at bit end, evaluate err = stp_err | (PAR_EN_latched & par_err).
  - err=0: data_valid=1 for exactly the next cycle.
  - err=1: frame_err=1 for exactly the next cycle.
  - data_valid and frame_err are never high together.
  - Next state is START if RX_IN==0 in that cycle (back-to-back frame, counters restart at 0), otherwise IDLE.
- par_err is ignored when PAR_EN was latched 0. Its stale sticky value must not cause frame_err.
- Enables are decoded from the registered state and counters, so they are glitch-free:
  - dat_samp_en=1 in every state except IDLE.
  - strt_chk_en=1 in START.
  - par_chk_en=1 in PARITY.
  - stp_chk_en=1 in STOP.
  - deser_en=1 for one cycle per data bit, in DATA at the check point.
- Latency: frame end to pulse is 1 clk.
  - A frame with parity spans 11*Prescale clks from entering START.
  - A frame without parity spans 10*Prescale clks.
- Changing PAR_EN mid-frame has no effect.
- Changing Prescale mid-frame is undefined; verification does not exercise it.

Decomposition:
- Shared include uart_rx_defs holds:
  - the state localparams;
  - DATA_BITS;
  - the check-point offset (Prescale/2+2), shared with the sampler and checkers.
- Sub-module edge_bit_counter holds the edge/bit counters.
  - Inputs: enable (state != IDLE) and Prescale.
  - Outputs: edge_count, bit_count, and a bit-end flag.
  - The FSM instantiates it once.

Test Plan:
1. Prescale=8, PAR_EN=1, RX frame 0xA5 with correct parity, checkers held 0 -> deser_en pulses 8 times; data_valid pulse exactly 88 clks after entering START; frame_err stays 0.
2. Prescale=16, PAR_EN=0, par_err tied 1 -> data_valid pulse 160 clks after START; frame_err stays 0; par_chk_en never asserted.
3. Prescale=8, strt_glitch=1 at START bit end -> back to IDLE; counters 0; no deser_en, data_valid or frame_err.
4. Prescale=32, PAR_EN=1, par_err=1 at stop end -> frame_err one-cycle pulse; data_valid stays 0. Repeat with stp_err=1 and PAR_EN=0 -> frame_err.
5. Two back-to-back frames with RX_IN low on the stop-end cycle -> direct STOP->START; second data_valid exactly 88 clks (Prescale=8) after the first.
6. rst pulled low at DATA bit 4, edge 3 (between clk edges) -> outputs and counters 0 immediately; after release, RX_IN=1 keeps the FSM in IDLE.
